// File: rtl/ofs_pcie_ss_wr_commit_gen.sv
// Per-stream store-commit tag queues, round-robin merged into one registered commit slot.
// Accept-to-commit is 1 cycle through an empty queue; ev_ready depends only on registered occupancy.
module ofs_pcie_ss_wr_commit_gen #(
   parameter int   NUM_STREAMS    = 2,
   parameter int   FIFO_DEPTH     = 8,
   parameter int   TAG_WIDTH      = 10,
   parameter logic WR_COMMIT_CHAN = 1'b0,
   localparam int  SW             = (NUM_STREAMS > 1) ? $clog2(NUM_STREAMS) : 1,
   localparam int  AW             = $clog2(FIFO_DEPTH),
   localparam int  CW             = AW + 1
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic [NUM_STREAMS-1:0]           ev_valid,
   input  logic [NUM_STREAMS*TAG_WIDTH-1:0] ev_tag,
   output logic [NUM_STREAMS-1:0]           ev_ready,
   output logic                             commit_valid,
   input  logic                             commit_ready,
   output logic [SW-1:0]                    commit_stream,
   output logic [TAG_WIDTH-1:0]             commit_tag,
   output logic                             commit_chan,
   output logic [NUM_STREAMS*CW-1:0]        pending_cnt,
   output logic                             overflow_err
);

   typedef enum logic {IDLE, HOLD} state_t;

   state_t                 state, state_nxt;
   logic [TAG_WIDTH-1:0]   mem    [NUM_STREAMS][FIFO_DEPTH];
   logic [AW-1:0]          wr_ptr [NUM_STREAMS];
   logic [AW-1:0]          rd_ptr [NUM_STREAMS];
   logic [CW-1:0]          cnt    [NUM_STREAMS];
   logic [SW-1:0]          last_grant;

   logic [NUM_STREAMS-1:0] push, nonempty, cand, fifo_wr, fifo_rd;
   logic                   grant_vld, load;
   logic [SW-1:0]          grant;
   logic [TAG_WIDTH-1:0]   grant_tag;

   assign commit_chan = WR_COMMIT_CHAN;

   for (genvar g = 0; g < NUM_STREAMS; g++) begin : g_stream
      assign ev_ready[g]               = (cnt[g] != CW'(FIFO_DEPTH));
      assign pending_cnt[g*CW +: CW]   = cnt[g];
   end

   // An empty queue with a push this cycle is also a candidate: its tag bypasses into the slot.
   always_comb begin
      push     = '0;
      nonempty = '0;
      cand     = '0;
      for (int i = 0; i < NUM_STREAMS; i++) begin
         push[i]     = ev_valid[i] & ev_ready[i];
         nonempty[i] = (cnt[i] != '0);
         cand[i]     = nonempty[i] | push[i];
      end
   end

   always_comb begin
      int idx;
      idx       = 0;
      grant_vld = 1'b0;
      grant     = '0;
      for (int k = 1; k <= NUM_STREAMS; k++) begin
         idx = (int'(last_grant) + k) % NUM_STREAMS;
         if (!grant_vld && cand[idx]) begin
            grant_vld = 1'b1;
            grant     = SW'(idx);
         end
      end
   end

   always_comb begin
      grant_tag = ev_tag[int'(grant)*TAG_WIDTH +: TAG_WIDTH];
      if (nonempty[grant])
         grant_tag = mem[grant][rd_ptr[grant]];
   end

   always_comb begin
      state_nxt    = state;
      load         = 1'b0;
      commit_valid = (state == HOLD);
      case (state)
         IDLE: begin
            if (grant_vld) begin
               state_nxt = HOLD;
               load      = 1'b1;
            end
         end
         HOLD: begin
            if (commit_ready) begin
               load      = grant_vld;
               state_nxt = grant_vld ? HOLD : IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      fifo_wr = '0;
      fifo_rd = '0;
      for (int i = 0; i < NUM_STREAMS; i++) begin
         fifo_rd[i] = load && (grant == SW'(i)) && nonempty[i];
         fifo_wr[i] = push[i] && !(load && (grant == SW'(i)) && !nonempty[i]);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_STREAMS; i++) begin
            wr_ptr[i] <= '0;
            rd_ptr[i] <= '0;
            cnt[i]    <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_STREAMS; i++) begin
            wr_ptr[i] <= wr_ptr[i] + AW'(fifo_wr[i]);
            rd_ptr[i] <= rd_ptr[i] + AW'(fifo_rd[i]);
            cnt[i]    <= cnt[i] + CW'(fifo_wr[i]) - CW'(fifo_rd[i]);
         end
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_STREAMS; i++) begin
         if (fifo_wr[i])
            mem[i][wr_ptr[i]] <= ev_tag[i*TAG_WIDTH +: TAG_WIDTH];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         commit_tag    <= '0;
         commit_stream <= '0;
         last_grant    <= SW'(NUM_STREAMS - 1);
         overflow_err  <= 1'b0;
      end else begin
         if (load) begin
            commit_tag    <= grant_tag;
            commit_stream <= grant;
            last_grant    <= grant;
         end
         if (|(ev_valid & ~ev_ready))
            overflow_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_ofs_pcie_ss_wr_commit_gen.sv
// Directed and randomized checks of the write-commit generator against a tag scoreboard.
module tb_ofs_pcie_ss_wr_commit_gen;
   localparam int NS    = 2;
   localparam int DEPTH = 8;
   localparam int TW    = 10;
   localparam int CW    = 4;

   typedef struct packed {
      logic [0:0]    s;
      logic [TW-1:0] t;
   } ent_t;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic [NS-1:0]    ev_valid = '0;
   logic [NS*TW-1:0] ev_tag = '0;
   logic [NS-1:0]    ev_ready;
   logic             commit_valid;
   logic             commit_ready = 1'b0;
   logic [0:0]       commit_stream;
   logic [TW-1:0]    commit_tag;
   logic             commit_chan;
   logic [NS*CW-1:0] pending_cnt;
   logic             overflow_err;

   int   n_checks = 0;
   int   n_fail   = 0;
   ent_t sb[$];

   always #5 clk = ~clk;

   ofs_pcie_ss_wr_commit_gen #(
      .NUM_STREAMS(NS), .FIFO_DEPTH(DEPTH), .TAG_WIDTH(TW), .WR_COMMIT_CHAN(1'b0)
   ) dut (
      .clk(clk), .rst_n(rst_n), .ev_valid(ev_valid), .ev_tag(ev_tag), .ev_ready(ev_ready),
      .commit_valid(commit_valid), .commit_ready(commit_ready), .commit_stream(commit_stream),
      .commit_tag(commit_tag), .commit_chan(commit_chan), .pending_cnt(pending_cnt),
      .overflow_err(overflow_err)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n        = 1'b0;
      ev_valid     = '0;
      ev_tag       = '0;
      commit_ready = 1'b0;
      repeat (2) tick();
      rst_n = 1'b1;
      tick();
   endtask

   function automatic logic [CW-1:0] pc(input int s);
      return pending_cnt[s*CW +: CW];
   endfunction

   task automatic push1(input int s, input logic [TW-1:0] t);
      ev_valid          = '0;
      ev_valid[s]       = 1'b1;
      ev_tag[s*TW +: TW] = t;
      tick();
      ev_valid = '0;
   endtask

   // Scoreboard pop: the commit must match the oldest outstanding tag of its stream.
   task automatic sb_pop_check();
      int idx;
      idx = -1;
      for (int i = 0; i < sb.size(); i++)
         if (idx < 0 && sb[i].s == commit_stream) idx = i;
      if (idx < 0) begin
         chk("rnd_spurious_commit", 32'd1, 32'd0);
      end else begin
         chk("rnd_order", commit_tag, sb[idx].t);
         sb.delete(idx);
      end
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [TW-1:0] exp_seq [8];
      logic [TW-1:0] held_tag;
      logic [0:0]    held_stream;
      logic          stalled;
      int            seen, n, seq0, seq1;

      // Reset state
      do_reset();
      chk("rst_valid", commit_valid, 0);
      chk("rst_tag", commit_tag, 0);
      chk("rst_stream", commit_stream, 0);
      chk("rst_pending", pending_cnt, 0);
      chk("rst_overflow", overflow_err, 0);
      chk("rst_ev_ready", ev_ready, 2'b11);

      // Single event, one-cycle latency
      commit_ready = 1'b1;
      push1(0, 10'h12A);
      chk("single_valid", commit_valid, 1);
      chk("single_tag", commit_tag, 10'h12A);
      chk("single_stream", commit_stream, 0);
      chk("single_chan", commit_chan, 0);
      tick();
      chk("single_done", commit_valid, 0);

      // Fill stream 1 with the slot stalled, then overflow
      do_reset();
      for (int k = 0; k < 9; k++) begin
         chk("fill_ready", ev_ready[1], 1);
         push1(1, TW'(10'h200 + k));
      end
      chk("fill_valid", commit_valid, 1);
      chk("fill_tag", commit_tag, 10'h200);
      chk("fill_stream", commit_stream, 1);
      chk("fill_pending", pc(1), 8);
      chk("fill_not_ready", ev_ready[1], 0);
      chk("fill_no_ovf_yet", overflow_err, 0);
      push1(1, 10'h2FF);
      chk("fill_overflow", overflow_err, 1);
      chk("fill_pending_hold", pc(1), 8);
      commit_ready = 1'b1;
      for (int k = 0; k < 9; k++) begin
         chk("fill_drain_valid", commit_valid, 1);
         chk("fill_drain_tag", commit_tag, TW'(10'h200 + k));
         tick();
      end
      chk("fill_drain_empty", commit_valid, 0);

      // Full queue popped while a push is offered: push refused
      do_reset();
      for (int k = 0; k < 9; k++) push1(0, TW'(10'h100 + k));
      chk("fullpop_pending", pc(0), 8);
      commit_ready = 1'b1;
      ev_valid[0]  = 1'b1;
      ev_tag[TW-1:0] = 10'h3FF;
      chk("fullpop_refused", ev_ready[0], 0);
      tick();
      ev_valid     = '0;
      commit_ready = 1'b0;
      chk("fullpop_pending7", pc(0), 7);
      chk("fullpop_ready_again", ev_ready[0], 1);
      chk("fullpop_next_tag", commit_tag, 10'h101);
      chk("fullpop_overflow", overflow_err, 1);
      commit_ready = 1'b1;
      for (int k = 1; k < 9; k++) begin
         chk("fullpop_drain_tag", commit_tag, TW'(10'h100 + k));
         tick();
      end
      chk("fullpop_no_extra", commit_valid, 0);

      // Round-robin fairness between two loaded streams
      do_reset();
      for (int k = 0; k < 4; k++) begin
         ev_valid = 2'b11;
         ev_tag   = {TW'(10'h0B0 + k), TW'(10'h0A0 + k)};
         tick();
      end
      ev_valid = '0;
      for (int k = 0; k < 4; k++) begin
         exp_seq[2*k]   = TW'(10'h0A0 + k);
         exp_seq[2*k+1] = TW'(10'h0B0 + k);
      end
      commit_ready = 1'b1;
      for (int j = 0; j < 8; j++) begin
         chk("rr_valid", commit_valid, 1);
         chk("rr_tag", commit_tag, exp_seq[j]);
         chk("rr_stream", commit_stream, j % 2);
         tick();
      end
      chk("rr_empty", commit_valid, 0);

      // Reset in the middle of a stalled transfer
      do_reset();
      for (int k = 0; k < 4; k++) push1(0, TW'(10'h050 + k));
      chk("midrst_pending_pre", pc(0), 3);
      chk("midrst_valid_pre", commit_valid, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_valid", commit_valid, 0);
      chk("midrst_pending", pending_cnt, 0);
      tick();
      rst_n        = 1'b1;
      commit_ready = 1'b1;
      seen = 0;
      for (int k = 0; k < 12; k++) begin
         if (commit_valid) seen++;
         tick();
      end
      chk("midrst_no_commit", seen, 0);

      // Random pushes with random backpressure against the scoreboard
      do_reset();
      sb.delete();
      stalled = 1'b0;
      held_tag = '0;
      held_stream = '0;
      seq0 = 0;
      seq1 = 0;
      for (int cyc = 0; cyc < 660; cyc++) begin
         if (stalled) begin
            chk("bp_valid_stable", commit_valid, 1);
            chk("bp_tag_stable", commit_tag, held_tag);
            chk("bp_stream_stable", commit_stream, held_stream);
         end
         for (int s = 0; s < NS; s++) begin
            n = 0;
            foreach (sb[i]) if (int'(sb[i].s) == s) n++;
            chk("rnd_occupancy", int'(pc(s)) + ((commit_valid && int'(commit_stream) == s) ? 1 : 0), n);
         end
         ev_valid = '0;
         if (cyc < 600) begin
            commit_ready = 1'($urandom_range(0, 1));
            if (ev_ready[0] && $urandom_range(0, 2) != 0) begin
               ev_valid[0] = 1'b1;
               ev_tag[0*TW +: TW] = TW'(seq0);
               seq0++;
            end
            if (ev_ready[1] && $urandom_range(0, 2) != 0) begin
               ev_valid[1] = 1'b1;
               ev_tag[1*TW +: TW] = TW'(seq1 + 512);
               seq1++;
            end
         end else begin
            commit_ready = 1'b1;
         end
         if (commit_valid && commit_ready) sb_pop_check();
         for (int s = 0; s < NS; s++)
            if (ev_valid[s]) sb.push_back('{s: 1'(s), t: ev_tag[s*TW +: TW]});
         stalled     = commit_valid && !commit_ready;
         held_tag    = commit_tag;
         held_stream = commit_stream;
         tick();
      end
      ev_valid = '0;
      chk("rnd_all_committed", sb.size(), 0);
      chk("rnd_idle_at_end", commit_valid, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/ofs_pcie_ss_wr_commit_gen.md
OFS_PCIE_SS_WR_COMMIT_GEN -- requirements
Module: ofs_pcie_ss_wr_commit_gen

Interface
REQ-001 Parameter NUM_STREAMS, default 2, number of TX streams observed for commit requests (legal 1..4).
REQ-002 Parameter FIFO_DEPTH, default 8, per-stream pending-commit entries (power of 2, >= 2).
REQ-003 Parameter TAG_WIDTH, default 10, width of the commit tag echoed in the commit message.
REQ-004 Parameter WR_COMMIT_CHAN, default 0 (PCIE_CHAN_A), RX channel tag driven on commit_chan.
REQ-005 clk  in  1  single clock for all logic.
REQ-006 rst_n  in  1  reset; asynchronous assert, active-low.
REQ-007 ev_valid  in  NUM_STREAMS  per stream: a write or interrupt with the store-commit tuser bit set reached the ordering point.
REQ-008 ev_tag  in  NUM_STREAMS*TAG_WIDTH  per-stream tag of the event; stream i at bits [i*TAG_WIDTH +: TAG_WIDTH].
REQ-009 ev_ready  out  NUM_STREAMS  per stream: event accepted when ev_valid & ev_ready.
REQ-010 commit_valid  out  1  commit message (dataless completion) available.
REQ-011 commit_ready  in  1  downstream accepts commit.
REQ-012 commit_stream  out  clog2(NUM_STREAMS) (min 1)  originating stream of the commit.
REQ-013 commit_tag  out  TAG_WIDTH  tag of the committed request.
REQ-014 commit_chan  out  1  constant WR_COMMIT_CHAN.
REQ-015 pending_cnt  out  NUM_STREAMS*(clog2(FIFO_DEPTH)+1)  per-stream occupancy.
REQ-016 overflow_err  out  1  sticky: ev_valid seen while ev_ready low.

Function
REQ-017 Each stream SHALL own one FIFO of FIFO_DEPTH tags; ev_ready[i] = !full[i], derived from registered state only (no combinational path from commit_ready).
REQ-018 A full FIFO SHALL not accept a push even if it is popped in the same cycle.
REQ-019 Simultaneous push and pop on a non-full, non-empty FIFO SHALL leave occupancy unchanged and preserve order.
REQ-020 FIFO pointers SHALL wrap modulo FIFO_DEPTH; occupancy SHALL use an extra bit so full (count==FIFO_DEPTH) and empty are distinct.
REQ-021 Output stage SHALL be a single register slot: states IDLE (commit_valid=0) and HOLD (commit_valid=1).
REQ-022 IDLE->HOLD when any FIFO is non-empty; the selected FIFO is popped in that cycle and its head loaded into commit_tag/commit_stream.
REQ-023 HOLD with commit_ready=1 SHALL either reload from the next selected non-empty FIFO (stay HOLD, back-to-back, one commit per cycle) or go to IDLE if all FIFOs are empty.
REQ-024 HOLD with commit_ready=0 SHALL keep commit_valid, commit_tag, commit_stream stable.
REQ-025 Stream selection SHALL be round-robin starting after the last granted stream; pointer updates only on a pop; after reset last-grant = NUM_STREAMS-1 (stream 0 first).
REQ-026 Minimum latency: event accepted in cycle N -> commit_valid in cycle N+1 (empty FIFO, IDLE or HOLD-with-ready).
REQ-027 Commits from one stream SHALL leave in acceptance order; no reordering across a stream.
REQ-028 overflow_err SHALL set on any ev_valid[i] & !ev_ready[i] and clear only on reset.
REQ-029 pending_cnt[i] SHALL reflect FIFO occupancy registered, excluding the entry in the output slot.

Reset
REQ-030 On rst_n low, asynchronously: all FIFOs empty, state IDLE, commit_valid=0, commit_tag=0, commit_stream=0, pending_cnt=0, overflow_err=0, ev_ready all 1 after reset release (first rising clk).
REQ-031 Reset mid-transfer SHALL discard all pending and held commits; no commit is emitted for pre-reset events.

Verification
REQ-032 Single event: stream 0 ev_tag=0x12A at cycle N, commit_ready=1 -> commit_valid at N+1, commit_tag=0x12A, commit_stream=0, commit_chan=WR_COMMIT_CHAN.
REQ-033 Fill: commit_ready=0, push 9 events on stream 1 (FIFO_DEPTH=8) -> 1 in output slot, pending_cnt[1]=8, ev_ready[1]=0, then a 10th ev_valid sets overflow_err=1.
REQ-034 Fairness: streams 0 and 1 each queued tags A0..A3 / B0..B3, commit_ready=1 -> output order A0,B0,A1,B1,A2,B2,A3,B3 on consecutive cycles.
REQ-035 Backpressure: commit_ready toggled 0/1 randomly with random pushes -> per-stream tag order preserved, no loss, no duplicate, outputs stable while commit_valid & !commit_ready.
REQ-036 Full with pop: stream 0 full, commit_ready=1, ev_valid[0]=1 same cycle -> push refused (ev_ready[0]=0), count drops to 7, ev_ready[0]=1 next cycle.
REQ-037 Reset mid-operation: rst_n low while commit_valid=1 and pending_cnt[0]=3 -> commit_valid=0 immediately, pending_cnt=0, no further commits after release.
